// File: rtl/alu_pkg.sv
// Shared constants for the RV32I ALU execute stage: datapath width and funct3 encodings.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_ex_stage_shift.sv
// Barrel shifter for the execute stage: left logical, right logical or right arithmetic.
module alu_ex_stage_shift
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [4:0]      amount,
    input  logic            right,
    input  logic            arth,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = data << amount;
        if (right) begin
            if (arth) begin
                result = $unsigned($signed(data) >>> amount);
            end else begin
                result = data >> amount;
            end
        end
    end

endmodule

// File: rtl/alu_ex_stage.sv
// RV32I execute stage: decodes funct3/funct7[5] into an ALU op and holds the result
// in a single-entry EX/MEM register with valid/ready handshakes, flush and an op counter.
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             is_imm,
    input  logic [4:0]       rd_in,
    input  logic             wen_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [4:0]       rd_out,
    output logic             wen_out,
    output logic [CNT_W-1:0] op_count
);

    logic [XLEN-1:0] shift_res;
    logic [XLEN-1:0] alu_res;
    logic            accept;
    logic            drain;

    alu_ex_stage_shift u_shift (
        .data   (op_a),
        .amount (op_b[4:0]),
        .right  (funct3 == F3_SR),
        .arth   (funct7_5),
        .result (shift_res)
    );

    // The immediate form has no SUB encoding; bit 30 there is part of the immediate.
    always_comb begin
        alu_res = '0;
        case (funct3)
            F3_ADD:  alu_res = (funct7_5 && !is_imm) ? (op_a - op_b) : (op_a + op_b);
            F3_SLL:  alu_res = shift_res;
            F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            F3_XOR:  alu_res = op_a ^ op_b;
            F3_SR:   alu_res = shift_res;
            F3_OR:   alu_res = op_a | op_b;
            F3_AND:  alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
    end

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
            wen_out   <= 1'b0;
            op_count  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            wen_out   <= 1'b0;
        end else if (accept) begin
            // Covers simultaneous drain: the new op overwrites the one leaving this cycle.
            out_valid <= 1'b1;
            result    <= alu_res;
            rd_out    <= rd_in;
            wen_out   <= wen_in;
            op_count  <= op_count + CNT_W'(1);
        end else if (drain) begin
            out_valid <= 1'b0;
            wen_out   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Randomized and directed bench for alu_ex_stage against a behavioural pipeline/ALU model.
module tb_alu_ex_stage;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic [2:0]    funct3;
    logic          funct7_5;
    logic          is_imm;
    logic [4:0]    rd_in;
    logic          wen_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   result;
    logic [4:0]    rd_out;
    logic          wen_out;
    logic [CW-1:0] op_count;

    int n_chk = 0;
    int n_bad = 0;

    // behavioural model of the output register
    logic          m_valid;
    logic [31:0]   m_result;
    logic [4:0]    m_rd;
    logic          m_wen;
    int            m_count;
    logic          m_acc;

    alu_ex_stage #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .is_imm    (is_imm),
        .rd_in     (rd_in),
        .wen_in    (wen_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_out    (rd_out),
        .wen_out   (wen_out),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic f7, input logic imm);
        int unsigned sh;
        logic [31:0] fill;
        sh = int'(b % 32);
        case (f3)
            3'd0: ref_alu = (f7 && !imm) ? a - b : a + b;
            3'd1: ref_alu = a << sh;
            3'd2: ref_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: ref_alu = (a < b) ? 32'd1 : 32'd0;
            3'd4: ref_alu = a ^ b;
            3'd5: begin
                fill = (f7 && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                ref_alu = (a >> sh) | fill;
            end
            3'd6: ref_alu = a | b;
            default: ref_alu = a & b;
        endcase
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_result = '0;
        m_rd     = '0;
        m_wen    = 1'b0;
        m_count  = 0;
    endtask

    // Call at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        m_acc = in_valid && (!m_valid || out_ready) && !flush;
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
            m_wen   = 1'b0;
        end else if (m_acc) begin
            m_valid  = 1'b1;
            m_result = ref_alu(op_a, op_b, funct3, funct7_5, is_imm);
            m_rd     = rd_in;
            m_wen    = wen_in;
            m_count  = (m_count + 1) % (1 << CW);
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_wen   = 1'b0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("result", result, m_result);
        check("rd_out", 32'(rd_out), 32'(m_rd));
        check("wen_out", 32'(wen_out), 32'(m_wen));
        check("op_count", 32'(op_count), 32'(m_count));
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                         input logic f7, input logic imm, input logic [4:0] rd, input logic v);
        in_valid = v;
        op_a     = a;
        op_b     = b;
        funct3   = f3;
        funct7_5 = f7;
        is_imm   = imm;
        rd_in    = rd;
        wen_in   = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; op_a = 0; op_b = 0; funct3 = 0; funct7_5 = 0;
        is_imm = 0; rd_in = 0; wen_in = 0; flush = 0; out_ready = 1;
        model_reset();
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_wen", 32'(wen_out), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // directed ALU cases
        drive(32'd5, 32'd3, 3'b000, 1'b1, 1'b0, 5'd1, 1'b1); cycle();
        check("sub_5_3", result, 32'd2);
        drive(32'd5, 32'd3, 3'b000, 1'b1, 1'b1, 5'd2, 1'b1); cycle();
        check("addi_5_3", result, 32'd8);
        drive(32'h8000_0000, 32'h24, 3'b101, 1'b1, 1'b0, 5'd3, 1'b1); cycle();
        check("sra_4", result, 32'hF800_0000);
        drive(32'h8000_0000, 32'h24, 3'b101, 1'b0, 1'b0, 5'd4, 1'b1); cycle();
        check("srl_4", result, 32'h0800_0000);
        drive(32'h8000_0000, 32'h24, 3'b001, 1'b0, 1'b0, 5'd5, 1'b1); cycle();
        check("sll_4", result, 32'h0000_0000);
        drive(32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0, 1'b0, 5'd6, 1'b1); cycle();
        check("slt_neg1_1", result, 32'd1);
        drive(32'hFFFF_FFFF, 32'd1, 3'b011, 1'b0, 1'b0, 5'd7, 1'b1); cycle();
        check("sltu_max_1", result, 32'd0);
        drive(32'h8000_0001, 32'h21, 3'b101, 1'b1, 1'b1, 5'd8, 1'b1); cycle();
        check("srai_1", result, 32'hC000_0000);
        in_valid = 0; cycle();

        // backpressure: three ops, MEM stalls two cycles
        do_reset();
        out_ready = 1'b0;
        drive(32'd10, 32'd20, 3'b000, 1'b0, 1'b0, 5'd9, 1'b1); cycle();
        drive(32'd7, 32'd1, 3'b100, 1'b0, 1'b0, 5'd10, 1'b1); cycle();
        check("bp_in_ready0", 32'(in_ready), 32'd0);
        check("bp_hold", result, 32'd30);
        cycle();
        check("bp_hold2", result, 32'd30);
        out_ready = 1'b1; cycle();
        check("bp_op2", result, 32'd6);
        drive(32'hF0, 32'h0F, 3'b110, 1'b0, 1'b0, 5'd11, 1'b1); cycle();
        check("bp_op3", result, 32'hFF);
        in_valid = 0; cycle();
        check("bp_count3", 32'(op_count), 32'd3);
        check("bp_drained", 32'(out_valid), 32'd0);

        // flush while holding an op and with a new op presented
        drive(32'd1, 32'd1, 3'b000, 1'b0, 1'b0, 5'd12, 1'b1); cycle();
        flush = 1'b1;
        drive(32'd2, 32'd2, 3'b000, 1'b0, 1'b0, 5'd13, 1'b1); cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_wen", 32'(wen_out), 32'd0);
        check("flush_count", 32'(op_count), 32'd4);
        flush = 1'b0; in_valid = 0; cycle();

        // async reset in the middle of a stall
        out_ready = 1'b0;
        drive(32'd9, 32'd9, 3'b111, 1'b0, 1'b0, 5'd14, 1'b1); cycle();
        in_valid = 0; cycle();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(op_count), 32'd0);
        check("arst_wen", 32'(wen_out), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // counter wrap: 17 accepts on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            drive($urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 5'(i), 1'b1);
            cycle();
        end
        in_valid = 0; cycle();
        check("wrap_count", 32'(op_count), 32'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                  3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 5'($urandom),
                  $urandom_range(0, 3) != 0);
            wen_in    = 1'($urandom);
            flush     = $urandom_range(0, 9) == 0;
            out_ready = $urandom_range(0, 9) < 7;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
